// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART MMIO bridge
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

  localparam int UART_DATA_BITS = 8;

  localparam int STAT_RX_VALID   = 0;
  localparam int STAT_TX_FULL    = 1;
  localparam int STAT_TX_BUSY    = 2;
  localparam int STAT_FRAME_ERR  = 3;
  localparam int STAT_RX_OVERRUN = 4;

  localparam logic [31:0] UART_TX_ADDR     = 32'h8000_0008;
  localparam logic [31:0] UART_RX_ADDR     = 32'h8000_0004;
  localparam logic [31:0] UART_STATUS_ADDR = 32'h8000_0000;

endpackage

// File: rtl/uart_mmio_bridge_if.sv
// rtl/uart_mmio_bridge_if.sv - core-side strobe/data bundle of the UART bridge
interface uart_mmio_bridge_if;

  logic [uart_pkg::UART_DATA_BITS-1:0] i_data_in;
  logic                                i_data_in_valid;
  logic                                i_data_out_ready;
  logic [uart_pkg::UART_DATA_BITS-1:0] o_rx_data;
  logic                                o_rx_valid;
  logic                                o_tx_full;
  logic [31:0]                         o_status;

  modport master (
    output i_data_in, i_data_in_valid, i_data_out_ready,
    input  o_rx_data, o_rx_valid, o_tx_full, o_status
  );

  modport slave (
    input  i_data_in, i_data_in_valid, i_data_out_ready,
    output o_rx_data, o_rx_valid, o_tx_full, o_status
  );

endinterface

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - synchronous FIFO with wrap-bit pointers and registered head
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_pop;
  logic             do_push;

  assign o_empty = (wr_ptr == rd_ptr);
  assign o_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // A pop frees a slot first, so a push into a full FIFO is accepted alongside it.
  assign do_pop  = i_pop && !o_empty;
  assign do_push = i_push && (!o_full || do_pop);
  assign o_head  = mem[rd_ptr[AW-1:0]];

  // Storage and pointer update; memory is cleared so the head reads zero out of reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= i_push_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_mmio_bridge.sv
// rtl/uart_mmio_bridge.sv - 8N1 UART with TX/RX FIFOs behind core MMIO strobes
module uart_mmio_bridge
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  uart_mmio_bridge_if.slave   bus,
  input  logic                i_rx,
  output logic                o_tx
);

  localparam int             TW        = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0]  BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0]  HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]     LAST_BIT  = 3'(UART_DATA_BITS - 1);

  uart_state_e                tx_state, tx_state_n;
  logic [TW-1:0]              tx_timer, tx_timer_n;
  logic [2:0]                 tx_bit, tx_bit_n;
  logic [UART_DATA_BITS-1:0]  tx_shift, tx_shift_n;
  logic                       tx_q, tx_q_n;
  logic                       tx_pop, tx_empty;
  logic [UART_DATA_BITS-1:0]  tx_head;

  uart_state_e                rx_state, rx_state_n;
  logic [TW-1:0]              rx_timer, rx_timer_n;
  logic [2:0]                 rx_bit, rx_bit_n;
  logic [UART_DATA_BITS-1:0]  rx_shift, rx_shift_n;
  logic                       rx_meta, rx_sync, rx_prev;
  logic                       rx_push, rx_full, rx_empty;
  logic                       frame_err, frame_err_set;
  logic                       rx_overrun, overrun_set;

  uart_fifo #(.WIDTH(UART_DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_push(bus.i_data_in_valid), .i_push_data(bus.i_data_in), .i_pop(tx_pop),
    .o_full(bus.o_tx_full), .o_empty(tx_empty), .o_head(tx_head)
  );

  uart_fifo #(.WIDTH(UART_DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_push(rx_push), .i_push_data(rx_shift), .i_pop(bus.i_data_out_ready),
    .o_full(rx_full), .o_empty(rx_empty), .o_head(bus.o_rx_data)
  );

  assign o_tx           = tx_q;
  assign bus.o_rx_valid = !rx_empty;
  assign overrun_set    = rx_push && rx_full && !bus.i_data_out_ready;

  // TX next-state: load from FIFO in IDLE or straight after STOP so frames run back-to-back.
  always_comb begin
    tx_state_n = tx_state;
    tx_timer_n = tx_timer;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    tx_q_n     = tx_q;
    tx_pop     = 1'b0;
    unique case (tx_state)
      IDLE: begin
        tx_q_n = 1'b1;
        if (!tx_empty) begin
          tx_pop = 1'b1; tx_shift_n = tx_head; tx_timer_n = '0; tx_bit_n = '0;
          tx_q_n = 1'b0; tx_state_n = START;
        end
      end
      START: begin
        tx_timer_n = tx_timer + 1'b1;
        if (tx_timer == BIT_LAST) begin
          tx_timer_n = '0; tx_q_n = tx_shift[0]; tx_state_n = DATA;
        end
      end
      DATA: begin
        tx_timer_n = tx_timer + 1'b1;
        if (tx_timer == BIT_LAST) begin
          tx_timer_n = '0;
          if (tx_bit == LAST_BIT) begin
            tx_q_n = 1'b1; tx_state_n = STOP;
          end else begin
            tx_bit_n = tx_bit + 1'b1; tx_shift_n = {1'b0, tx_shift[UART_DATA_BITS-1:1]};
            tx_q_n = tx_shift[1];
          end
        end
      end
      STOP: begin
        tx_timer_n = tx_timer + 1'b1;
        if (tx_timer == BIT_LAST) begin
          tx_timer_n = '0;
          if (!tx_empty) begin
            tx_pop = 1'b1; tx_shift_n = tx_head; tx_bit_n = '0;
            tx_q_n = 1'b0; tx_state_n = START;
          end else begin
            tx_q_n = 1'b1; tx_state_n = IDLE;
          end
        end
      end
      default: tx_state_n = IDLE;
    endcase
  end

  // TX state register; the line output is registered and forced idle-high by reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tx_state <= IDLE; tx_timer <= '0; tx_bit <= '0; tx_shift <= '0; tx_q <= 1'b1;
    end else begin
      tx_state <= tx_state_n; tx_timer <= tx_timer_n; tx_bit <= tx_bit_n;
      tx_shift <= tx_shift_n; tx_q <= tx_q_n;
    end
  end

  // RX next-state: edge-triggered start, mid-bit sampling, stop bit decides push or frame error.
  always_comb begin
    rx_state_n    = rx_state;
    rx_timer_n    = rx_timer;
    rx_bit_n      = rx_bit;
    rx_shift_n    = rx_shift;
    rx_push       = 1'b0;
    frame_err_set = 1'b0;
    unique case (rx_state)
      IDLE: begin
        if (rx_prev && !rx_sync) begin
          rx_timer_n = '0; rx_state_n = START;
        end
      end
      START: begin
        rx_timer_n = rx_timer + 1'b1;
        if (rx_timer == HALF_LAST) begin
          rx_timer_n = '0; rx_bit_n = '0;
          rx_state_n = rx_sync ? IDLE : DATA;
        end
      end
      DATA: begin
        rx_timer_n = rx_timer + 1'b1;
        if (rx_timer == BIT_LAST) begin
          rx_timer_n = '0;
          rx_shift_n = {rx_sync, rx_shift[UART_DATA_BITS-1:1]};
          rx_bit_n   = rx_bit + 1'b1;
          if (rx_bit == LAST_BIT) rx_state_n = STOP;
        end
      end
      STOP: begin
        rx_timer_n = rx_timer + 1'b1;
        if (rx_timer == BIT_LAST) begin
          rx_timer_n    = '0;
          rx_push       = rx_sync;
          frame_err_set = !rx_sync;
          rx_state_n    = IDLE;
        end
      end
      default: rx_state_n = IDLE;
    endcase
  end

  // RX synchronizer, state register and sticky flags; a set beats a same-cycle pop clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta <= 1'b1; rx_sync <= 1'b1; rx_prev <= 1'b1;
      rx_state <= IDLE; rx_timer <= '0; rx_bit <= '0; rx_shift <= '0;
      frame_err <= 1'b0; rx_overrun <= 1'b0;
    end else begin
      rx_meta <= i_rx; rx_sync <= rx_meta; rx_prev <= rx_sync;
      rx_state <= rx_state_n; rx_timer <= rx_timer_n; rx_bit <= rx_bit_n;
      rx_shift <= rx_shift_n;
      frame_err  <= frame_err_set | (frame_err & !bus.i_data_out_ready);
      rx_overrun <= overrun_set | (rx_overrun & !bus.i_data_out_ready);
    end
  end

  // Status word for the SoC read mux.
  always_comb begin
    bus.o_status                  = '0;
    bus.o_status[STAT_RX_VALID]   = !rx_empty;
    bus.o_status[STAT_TX_FULL]    = bus.o_tx_full;
    bus.o_status[STAT_TX_BUSY]    = (tx_state != IDLE);
    bus.o_status[STAT_FRAME_ERR]  = frame_err;
    bus.o_status[STAT_RX_OVERRUN] = rx_overrun;
  end

endmodule

// File: tb/tb_uart_mmio_bridge.sv
// tb/tb_uart_mmio_bridge.sv - self-checking bench for uart_mmio_bridge
module tb_uart_mmio_bridge;
  import uart_pkg::*;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_drv = 1'b1;
  logic loop_en = 1'b0;
  logic i_rx;
  logic o_tx;

  uart_mmio_bridge_if bus();

  assign i_rx = loop_en ? o_tx : rx_drv;

  uart_mmio_bridge #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus), .i_rx(i_rx), .o_tx(o_tx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] rx_q[$];
  logic [7:0] tx_exp[$];
  logic       m_ferr = 1'b0;
  logic       m_ovr = 1'b0;
  bit         settled = 1'b0;
  bit         mon_en = 1'b1;
  int         tx_frames = 0;
  logic [7:0] mb;
  logic       mok;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_tx(input logic [7:0] d);
    bus.i_data_in = d;
    bus.i_data_in_valid = 1'b1;
    @(negedge clk);
    bus.i_data_in_valid = 1'b0;
  endtask

  task automatic pop_rx(input string name, input logic exp_valid, input logic [7:0] exp_data);
    chk({name, "_valid"}, bus.o_rx_valid, exp_valid);
    if (exp_valid) chk({name, "_data"}, bus.o_rx_data, exp_data);
    bus.i_data_out_ready = 1'b1;
    if (rx_q.size() != 0) void'(rx_q.pop_front());
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    @(negedge clk);
    bus.i_data_out_ready = 1'b0;
  endtask

  // Serial frame into i_rx; the model applies the frame's effect from the spec rules.
  task automatic send_rx(input logic [7:0] d, input logic stop, input bit pop_at_stop);
    settled = 1'b0;
    rx_drv = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      tick(CPB);
    end
    rx_drv = stop;
    tick(CPB);
    rx_drv = 1'b1;
    if (pop_at_stop) begin
      if (rx_q.size() != 0) chk("stop_pop_data", bus.o_rx_data, rx_q[0]);
      bus.i_data_out_ready = 1'b1;
      if (rx_q.size() != 0) void'(rx_q.pop_front());
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
    end
    if (!stop) m_ferr = 1'b1;
    else if (rx_q.size() == DEPTH) m_ovr = 1'b1;
    else rx_q.push_back(d);
    tick(1);
    bus.i_data_out_ready = 1'b0;
    tick(4);
    settled = 1'b1;
  endtask

  // Per-cycle compare of RX-side outputs against the model once the line is quiet.
  always begin
    @(posedge clk);
    #2;
    if (settled && rst_n) begin
      chk("rx_valid", bus.o_rx_valid, rx_q.size() != 0);
      if (rx_q.size() != 0) chk("rx_data", bus.o_rx_data, rx_q[0]);
      chk("status_rx_valid", bus.o_status[STAT_RX_VALID], rx_q.size() != 0);
      chk("frame_err", bus.o_status[STAT_FRAME_ERR], m_ferr);
      chk("rx_overrun", bus.o_status[STAT_RX_OVERRUN], m_ovr);
      chk("status_hi", bus.o_status[31:5], 32'd0);
    end
  end

  // TX line decoder: samples mid-bit and checks each frame against the expected byte queue.
  always begin
    @(negedge clk);
    if (mon_en && rst_n && o_tx === 1'b0) begin
      repeat (CPB / 2) @(negedge clk);
      mok = (o_tx === 1'b0);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        mb[i] = o_tx;
      end
      repeat (CPB) @(negedge clk);
      chk("tx_start_bit", mok, 1'b1);
      chk("tx_stop_bit", o_tx, 1'b1);
      tx_frames++;
      chk("tx_frame_expected", tx_exp.size() != 0, 1'b1);
      if (tx_exp.size() != 0) chk("tx_frame_byte", mb, tx_exp.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int f0;
    bit low_seen;
    logic [9:0] frame;
    bus.i_data_in = '0;
    bus.i_data_in_valid = 1'b0;
    bus.i_data_out_ready = 1'b0;

    tick(3);
    chk("rst_tx", o_tx, 1'b1);
    chk("rst_status", bus.o_status, 32'd0);
    chk("rst_rx_data", bus.o_rx_data, 8'h00);
    chk("rst_rx_valid", bus.o_rx_valid, 1'b0);
    chk("rst_tx_full", bus.o_tx_full, 1'b0);
    rst_n = 1'b1;
    tick(2);
    settled = 1'b1;

    // 1: single frame waveform for 8'hA5
    tx_exp.push_back(8'hA5);
    push_tx(8'hA5);
    lat = 1;
    while (o_tx !== 1'b0 && lat < 4) begin
      tick(1);
      lat++;
    end
    chk("t1_latency_le2", lat <= 2, 1'b1);
    frame = 10'b1_1010_0101_0;
    for (int i = 0; i < 40; i++) begin
      chk("t1_wave", o_tx, frame[i / CPB]);
      chk("t1_busy", bus.o_status[STAT_TX_BUSY], 1'b1);
      tick(1);
    end
    chk("t1_busy_fall", bus.o_status[STAT_TX_BUSY], 1'b0);
    tick(5);

    // 2: loopback two back-to-back bytes
    settled = 1'b0;
    loop_en = 1'b1;
    tx_exp.push_back(8'h3C);
    tx_exp.push_back(8'hC3);
    push_tx(8'h3C);
    push_tx(8'hC3);
    tick(100);
    loop_en = 1'b0;
    rx_q.push_back(8'h3C);
    rx_q.push_back(8'hC3);
    settled = 1'b1;
    tick(2);
    pop_rx("t2_pop0", 1'b1, 8'h3C);
    pop_rx("t2_pop1", 1'b1, 8'hC3);
    chk("t2_empty", bus.o_rx_valid, 1'b0);
    tick(3);

    // 3: framing error, cleared by a pop strobe on an empty FIFO
    send_rx(8'h55, 1'b0, 1'b0);
    chk("t3_ferr_set", bus.o_status[STAT_FRAME_ERR], 1'b1);
    chk("t3_no_push", bus.o_rx_valid, 1'b0);
    pop_rx("t3_pop_empty", 1'b0, 8'h00);
    chk("t3_ferr_clr", bus.o_status[STAT_FRAME_ERR], 1'b0);
    tick(3);

    // 4: ten pushes into an idle transmitter
    f0 = tx_frames;
    for (int i = 0; i < 9; i++) tx_exp.push_back(8'h10 + 8'(i));
    for (int i = 0; i < 10; i++) push_tx(8'h10 + 8'(i));
    chk("t4_tx_full", bus.o_tx_full, 1'b1);
    chk("t4_status_full", bus.o_status[STAT_TX_FULL], 1'b1);
    tick(9 * 10 * CPB + 60);
    chk("t4_frame_count", tx_frames - f0, 9);
    chk("t4_all_sent", tx_exp.size(), 0);
    chk("t4_not_full", bus.o_tx_full, 1'b0);

    // 5: RX overrun and pop coinciding with the stop sample
    for (int i = 0; i < 8; i++) begin
      send_rx(8'hA0 + 8'(i), 1'b1, 1'b0);
      tick(2);
    end
    send_rx(8'hFF, 1'b1, 1'b0);
    chk("t5_overrun_set", bus.o_status[STAT_RX_OVERRUN], 1'b1);
    chk("t5_head_kept", bus.o_rx_data, 8'hA0);
    tick(2);
    send_rx(8'h9A, 1'b1, 1'b1);
    chk("t5_overrun_clr", bus.o_status[STAT_RX_OVERRUN], 1'b0);
    for (int i = 0; i < 8; i++)
      pop_rx("t5_pop", 1'b1, (i < 7) ? 8'hA1 + 8'(i) : 8'h9A);
    chk("t5_empty", bus.o_rx_valid, 1'b0);
    tick(3);

    // 6: reset in the middle of TX data bit 4, then an RX glitch
    mon_en = 1'b0;
    settled = 1'b0;
    push_tx(8'h0F);
    lat = 1;
    while (o_tx !== 1'b0 && lat < 4) begin
      tick(1);
      lat++;
    end
    chk("t6_latency_le2", lat <= 2, 1'b1);
    tick(CPB + 4 * CPB + 1);
    chk("t6_bit4_low", o_tx, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t6_async_tx_high", o_tx, 1'b1);
    chk("t6_async_status", bus.o_status, 32'd0);
    tick(2);
    rst_n = 1'b1;
    rx_q.delete();
    tx_exp.delete();
    m_ferr = 1'b0;
    m_ovr = 1'b0;
    tick(1);
    chk("t6_tx_full", bus.o_tx_full, 1'b0);
    chk("t6_status", bus.o_status, 32'd0);
    chk("t6_rx_valid", bus.o_rx_valid, 1'b0);
    low_seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (o_tx !== 1'b1) low_seen = 1'b1;
      tick(1);
    end
    chk("t6_tx_stays_idle", low_seen, 1'b0);
    mon_en = 1'b1;
    settled = 1'b1;
    rx_drv = 1'b0;
    tick(1);
    rx_drv = 1'b1;
    tick(20);
    chk("t6_glitch_no_byte", bus.o_rx_valid, 1'b0);
    chk("t6_glitch_status", bus.o_status, 32'd0);

    tick(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
